// File: rtl/clk_meter_pkg.sv
// ---------------------------------------------------------------------------
// clk_meter_pkg
// Shared definitions for the clock frequency meter:
//   - meas_state_t   : measurement FSM state encoding
//   - SETTLE_CYCLES  : synchroniser flush length for the default depth
//   - settle_cycles(): flush length for an arbitrary synchroniser depth
//   - bin2gray / gray2bin : 32-bit code converters; narrower values are
//     zero-extended on the way in and truncated on the way out, which is
//     exact for both directions because the upper zero bits do not disturb
//     the lower bits of either transform.
// ---------------------------------------------------------------------------
package clk_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_REPORT  = 2'd3
  } meas_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int SETTLE_CYCLES   = DEF_SYNC_STAGES + 2;

  function automatic int settle_cycles(input int sync_stages);
    return sync_stages + 2;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/cdc_gray_cnt.sv
// ---------------------------------------------------------------------------
// cdc_gray_cnt
// Free-running edge counter in the monitored clock domain, carried into the
// sys_clk domain as a Gray code so that every sample is either the old or
// the new count, never a torn value.
// Ports:
//   i_sys_clk   : measurement clock
//   i_sys_rst_n : async active-low reset; also asserts the monitored-domain
//                 reset, which is released synchronously to i_mon_clk
//   i_mon_clk   : clock under test
//   o_cur_bin   : synchronised count, converted back to binary (sys_clk)
// ---------------------------------------------------------------------------
module cdc_gray_cnt
  import clk_meter_pkg::*;
#(
  parameter int GRAY_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst_n,
  input  logic              i_mon_clk,
  output logic [GRAY_W-1:0] o_cur_bin
);

  logic [SYNC_STAGES-1:0] r_mon_rst_sync;
  logic                   w_mon_rst_n;
  logic [GRAY_W-1:0]      r_mon_bin;
  logic [GRAY_W-1:0]      r_mon_gray;
  logic [GRAY_W-1:0]      r_gray_sync [SYNC_STAGES];

  // Reset asserts immediately, releases after SYNC_STAGES mon_clk edges.
  always_ff @(posedge i_mon_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_mon_rst_sync <= '0;
    end else begin
      r_mon_rst_sync <= (r_mon_rst_sync << 1) | SYNC_STAGES'(1);
    end
  end

  assign w_mon_rst_n = r_mon_rst_sync[SYNC_STAGES-1];

  always_ff @(posedge i_mon_clk or negedge w_mon_rst_n) begin
    if (!w_mon_rst_n) begin
      r_mon_bin  <= '0;
      r_mon_gray <= '0;
    end else begin
      r_mon_bin  <= r_mon_bin + 1'b1;
      r_mon_gray <= GRAY_W'(bin2gray(32'(r_mon_bin)));
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_gray_sync[i] <= '0;
      end
    end else begin
      r_gray_sync[0] <= r_mon_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_gray_sync[i] <= r_gray_sync[i-1];
      end
    end
  end

  assign o_cur_bin = GRAY_W'(gray2bin(32'(r_gray_sync[SYNC_STAGES-1])));

endmodule

// File: rtl/clk_freq_meter.sv
// ---------------------------------------------------------------------------
// clk_freq_meter
// Counts rising edges of mon_clk over a window of WIN_CYCLES sys_clk cycles
// and reports the count with an in-range / dead verdict.
// Ports:
//   sys_clk, sys_rst_n : measurement clock, async active-low reset
//   mon_clk            : clock under test
//   meas_en            : high = back-to-back windows, low = abort to idle
//   lo_thr, hi_thr     : inclusive in_range bounds, sampled at report time
//   freq_cnt           : edge count of the last completed window
//   freq_vld           : one-cycle pulse when freq_cnt updates
//   in_range, clk_dead : verdicts registered together with freq_cnt
//   busy               : high while settling or measuring
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for meas_en; busy low
// ST_SETTLE  | SYNC_STAGES+2 cycles flushing the synchroniser, no counting
// ST_MEASURE | WIN_CYCLES cycles accumulating the per-cycle edge delta
// ST_REPORT  | one cycle: publish result, then re-measure or go idle
// ---------------------------------------------------------------------------
module clk_freq_meter
  import clk_meter_pkg::*;
#(
  parameter int WIN_CYCLES  = 1024,
  parameter int CNT_W       = 16,
  parameter int GRAY_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             mon_clk,
  input  logic             meas_en,
  input  logic [CNT_W-1:0] lo_thr,
  input  logic [CNT_W-1:0] hi_thr,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             freq_vld,
  output logic             in_range,
  output logic             clk_dead,
  output logic             busy
);

  localparam int L_SETTLE = settle_cycles(SYNC_STAGES);
  localparam int WIN_W    = $clog2(WIN_CYCLES + 1);
  localparam int SUM_W    = ((CNT_W > GRAY_W) ? CNT_W : GRAY_W) + 1;
  localparam logic [WIN_W-1:0] L_WIN_LAST    = WIN_W'(WIN_CYCLES - 1);
  localparam logic [WIN_W-1:0] L_SETTLE_LAST = WIN_W'(L_SETTLE - 1);

  meas_state_t       r_state;
  logic [WIN_W-1:0]  r_win;
  logic [CNT_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_freq_cnt;
  logic              r_freq_vld;
  logic              r_in_range;
  logic              r_clk_dead;
  logic              r_busy;
  logic [GRAY_W-1:0] w_cur_bin;
  logic [GRAY_W-1:0] r_prev_bin;
  logic [GRAY_W-1:0] w_delta;
  logic [SUM_W-1:0]  w_sum;
  logic [CNT_W-1:0]  w_acc_next;

  cdc_gray_cnt #(
    .GRAY_W      (GRAY_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cdc_gray_cnt (
    .i_sys_clk   (sys_clk),
    .i_sys_rst_n (sys_rst_n),
    .i_mon_clk   (mon_clk),
    .o_cur_bin   (w_cur_bin)
  );

  // Modular subtraction absorbs counter wrap as long as fewer than
  // 2^GRAY_W edges arrive per sys_clk cycle.
  assign w_delta    = w_cur_bin - r_prev_bin;
  assign w_sum      = SUM_W'(r_acc) + SUM_W'(w_delta);
  assign w_acc_next = (w_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : w_sum[CNT_W-1:0];

  // Tracks every cycle so back-to-back windows lose no continuity.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_prev_bin <= '0;
    end else begin
      r_prev_bin <= w_cur_bin;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_win      <= '0;
      r_acc      <= '0;
      r_freq_cnt <= '0;
      r_freq_vld <= 1'b0;
      r_in_range <= 1'b0;
      r_clk_dead <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_freq_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_win <= '0;
          r_acc <= '0;
          if (meas_en) begin
            r_state <= ST_SETTLE;
            r_busy  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          r_acc <= '0;
          if (!meas_en) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_win == L_SETTLE_LAST) begin
            r_win   <= '0;
            r_state <= ST_MEASURE;
          end else begin
            r_win <= r_win + 1'b1;
          end
        end
        ST_MEASURE: begin
          if (!meas_en) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_acc_next;
            if (r_win == L_WIN_LAST) begin
              r_win   <= '0;
              r_state <= ST_REPORT;
              r_busy  <= 1'b0;
            end else begin
              r_win <= r_win + 1'b1;
            end
          end
        end
        ST_REPORT: begin
          r_freq_cnt <= r_acc;
          r_in_range <= (r_acc >= lo_thr) && (r_acc <= hi_thr);
          r_clk_dead <= (r_acc == '0);
          r_freq_vld <= 1'b1;
          r_acc      <= '0;
          r_win      <= '0;
          if (meas_en) begin
            r_state <= ST_MEASURE;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign freq_cnt = r_freq_cnt;
  assign freq_vld = r_freq_vld;
  assign in_range = r_in_range;
  assign clk_dead = r_clk_dead;
  assign busy     = r_busy;

endmodule

// File: tb/tb_clk_freq_meter.sv
`timescale 1ps/1ps
module tb_clk_freq_meter;

  localparam int  SYS_PERIOD = 10000;
  localparam int  WIN        = 1024;
  localparam int  FIRST      = 1 + (2 + 2) + WIN + 1;
  localparam int  PERIOD     = WIN + 1;
  localparam int  WIN2       = 16;
  localparam int  FIRST2     = 1 + (2 + 2) + WIN2 + 1;

  typedef struct {
    longint exp_cyc;
    int     cnt_lo;
    int     cnt_hi;
    bit     rng_known;
    bit     exp_rng;
    bit     exp_dead;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        mon_clk;
  logic        meas_en;
  logic [15:0] lo_thr, hi_thr;
  logic [15:0] freq_cnt;
  logic        freq_vld, in_range, clk_dead, busy;

  logic        meas_en2;
  logic [4:0]  lo_thr2, hi_thr2, freq_cnt2;
  logic        freq_vld2, in_range2, clk_dead2, busy2;

  int     mon_half = 20000;
  bit     mon_stop = 1'b0;
  longint cyc = 0;
  int     n_checks = 0;
  int     n_errors = 0;
  exp_t   exp_q[$];

  clk_freq_meter #(.WIN_CYCLES(WIN), .CNT_W(16), .GRAY_W(4), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mon_clk(mon_clk), .meas_en(meas_en),
    .lo_thr(lo_thr), .hi_thr(hi_thr), .freq_cnt(freq_cnt), .freq_vld(freq_vld),
    .in_range(in_range), .clk_dead(clk_dead), .busy(busy));

  clk_freq_meter #(.WIN_CYCLES(WIN2), .CNT_W(5), .GRAY_W(4), .SYNC_STAGES(2)) dut_sat (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mon_clk(mon_clk), .meas_en(meas_en2),
    .lo_thr(lo_thr2), .hi_thr(hi_thr2), .freq_cnt(freq_cnt2), .freq_vld(freq_vld2),
    .in_range(in_range2), .clk_dead(clk_dead2), .busy(busy2));

  always #(SYS_PERIOD/2) sys_clk = ~sys_clk;

  initial begin
    mon_clk = 1'b0;
    forever begin
      if (mon_stop) begin
        mon_clk = 1'b0;
        #1000;
      end else begin
        #(mon_half) mon_clk = ~mon_clk;
      end
    end
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit ok, input longint act, input longint exp_v);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
    end
  endtask

  // Scoreboard monitor: every freq_vld pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && freq_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vld", 1'b0, 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("vld_cycle", cyc == e.exp_cyc, cyc, e.exp_cyc);
          chk_rng("freq_cnt", longint'(freq_cnt), e.cnt_lo, e.cnt_hi);
          if (e.rng_known) chk("in_range", in_range == e.exp_rng, longint'(in_range), longint'(e.exp_rng));
          chk("clk_dead", clk_dead == e.exp_dead, longint'(clk_dead), longint'(e.exp_dead));
        end
      end
    end
  end

  // Reference: a steady clock of period 2*half gives WIN*SYS_PERIOD/(2*half)
  // edges per window, give or take one from sampling phase.
  task automatic run_win(input int n, input int half_ps, input bit stop,
                         input bit rand_thr, input int lo_in, input int hi_in);
    real    nom;
    int     bl, bh, lo, hi, mode;
    longint en;
    exp_t   e;
    if (stop) mon_stop = 1'b1;
    else begin
      mon_half = half_ps;
      mon_stop = 1'b0;
    end
    repeat (10) @(negedge sys_clk);
    if (stop) begin
      bl = 0;
      bh = 0;
    end else begin
      nom = (real'(WIN) * real'(SYS_PERIOD)) / (2.0 * real'(half_ps));
      bl  = int'($ceil(nom - 1.0));
      bh  = int'($floor(nom + 1.0));
      if (bl < 0) bl = 0;
    end
    lo = lo_in;
    hi = hi_in;
    if (rand_thr) begin
      mode = $urandom_range(0, 3);
      if (mode == 1 && bl < 2) mode = 0;
      case (mode)
        0: begin
          lo = bl - int'($urandom_range(0, 5));
          if (lo < 0) lo = 0;
          hi = bh + int'($urandom_range(0, 5));
        end
        1: begin
          hi = int'($urandom_range(0, bl - 1));
          lo = int'($urandom_range(0, hi));
        end
        2: begin
          lo = bh + 1 + int'($urandom_range(0, 50));
          hi = lo + int'($urandom_range(0, 50));
        end
        default: begin
          lo = bh + 1 + int'($urandom_range(0, 10));
          hi = int'($urandom_range(0, bh));
        end
      endcase
    end
    lo_thr = 16'(lo);
    hi_thr = 16'(hi);
    e.cnt_lo    = bl;
    e.cnt_hi    = bh;
    e.exp_dead  = (bh == 0);
    e.rng_known = 1'b1;
    if (lo > hi || hi < bl || lo > bh) e.exp_rng = 1'b0;
    else if (lo <= bl && hi >= bh)     e.exp_rng = 1'b1;
    else                               e.rng_known = 1'b0;
    en = cyc;
    meas_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      e.exp_cyc = en + FIRST + k * PERIOD;
      exp_q.push_back(e);
    end
    // Drop enable just before the final report edge so that report is kept.
    while (cyc < en + FIRST + (n - 1) * PERIOD - 1) @(negedge sys_clk);
    meas_en = 1'b0;
    repeat (5) @(negedge sys_clk);
    chk("busy_idle_after_run", busy == 1'b0, longint'(busy), 0);
    chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    longint en;
    bit     seen;
    exp_t   e;
    sys_rst_n = 1'b0;
    meas_en   = 1'b0;
    meas_en2  = 1'b0;
    lo_thr    = '0;
    hi_thr    = '0;
    lo_thr2   = 5'd0;
    hi_thr2   = 5'd31;
    repeat (3) @(negedge sys_clk);
    chk("rst_freq_cnt", freq_cnt == 16'd0, longint'(freq_cnt), 0);
    chk("rst_freq_vld", freq_vld == 1'b0, longint'(freq_vld), 0);
    chk("rst_in_range", in_range == 1'b0, longint'(in_range), 0);
    chk("rst_clk_dead", clk_dead == 1'b0, longint'(clk_dead), 0);
    chk("rst_busy", busy == 1'b0, longint'(busy), 0);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // 25 MHz, back-to-back windows, directed thresholds.
    run_win(2, 20000, 1'b0, 1'b0, 250, 262);
    // About 3.5x sys_clk: exercises multi-edge deltas per cycle.
    run_win(1, 1428, 1'b0, 1'b1, 0, 0);
    // Stopped clock: dead, and out of range with lo_thr = 1.
    run_win(1, 0, 1'b1, 1'b0, 1, 100);

    // Abort mid-window: no pulse, outputs hold the dead result.
    mon_half = 5000;
    mon_stop = 1'b0;
    repeat (10) @(negedge sys_clk);
    en = cyc;
    meas_en = 1'b1;
    while (cyc < en + 5 + 500) @(negedge sys_clk);
    chk("busy_in_measure", busy == 1'b1, longint'(busy), 1);
    lo_thr  = 16'd0;
    meas_en = 1'b0;
    @(negedge sys_clk);
    chk("busy_after_abort", busy == 1'b0, longint'(busy), 0);
    repeat (20) @(negedge sys_clk);
    chk("abort_hold_cnt", freq_cnt == 16'd0, longint'(freq_cnt), 0);
    chk("abort_hold_dead", clk_dead == 1'b1, longint'(clk_dead), 1);
    chk("abort_hold_range", in_range == 1'b0, longint'(in_range), 0);

    for (int r = 0; r < 4; r++) begin
      run_win(int'($urandom_range(1, 2)), int'($urandom_range(1300, 20000)), 1'b0, 1'b1, 0, 0);
    end

    // Saturation on the short-window instance: ~50 edges into a 5-bit count.
    mon_half = 1600;
    repeat (10) @(negedge sys_clk);
    en = cyc;
    meas_en2 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge sys_clk);
      if (freq_vld2) begin
        seen = 1'b1;
        chk("sat_vld_cycle", cyc == en + FIRST2, cyc, en + FIRST2);
        chk("sat_freq_cnt", freq_cnt2 == 5'd31, longint'(freq_cnt2), 31);
        chk("sat_in_range", in_range2 == 1'b1, longint'(in_range2), 1);
        chk("sat_clk_dead", clk_dead2 == 1'b0, longint'(clk_dead2), 0);
      end
    end
    if (!seen) chk("sat_vld_timeout", 1'b0, 0, 1);
    meas_en2 = 1'b0;
    repeat (10) @(negedge sys_clk);

    // Reset mid-window after a good result, then standard first latency.
    mon_half = 2000;
    repeat (10) @(negedge sys_clk);
    lo_thr = 16'd2500;
    hi_thr = 16'd2600;
    e.cnt_lo    = 2559;
    e.cnt_hi    = 2561;
    e.rng_known = 1'b1;
    e.exp_rng   = 1'b1;
    e.exp_dead  = 1'b0;
    en = cyc;
    meas_en = 1'b1;
    e.exp_cyc = en + FIRST;
    exp_q.push_back(e);
    while (cyc < en + FIRST + 300) @(negedge sys_clk);
    #2000;
    sys_rst_n = 1'b0;
    #1000;
    chk("midrst_freq_cnt", freq_cnt == 16'd0, longint'(freq_cnt), 0);
    chk("midrst_freq_vld", freq_vld == 1'b0, longint'(freq_vld), 0);
    chk("midrst_in_range", in_range == 1'b0, longint'(in_range), 0);
    chk("midrst_clk_dead", clk_dead == 1'b0, longint'(clk_dead), 0);
    chk("midrst_busy", busy == 1'b0, longint'(busy), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    en = cyc;
    e.exp_cyc = en + FIRST;
    exp_q.push_back(e);
    while (cyc < en + FIRST - 1) @(negedge sys_clk);
    meas_en = 1'b0;
    repeat (20) @(negedge sys_clk);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge sys_clk);
    chk("final_queue_empty", exp_q.size() == 0, exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
